// File: rtl/sram_1rw_masked_init_if.sv
// ----------------------------------------------------------------------------
// sram_1rw_masked_init_if
//
// Access bundle for the single-port masked SRAM with built-in init sweep.
// Clock and reset are not part of the bundle; they stay plain module ports.
//
// Signals:
//   csb0       master->slave  active-low chip select
//   web0_aL    master->slave  active-low write enable (0 = write, 1 = read)
//   wmask0     master->slave  per-granule write enable, bit i covers
//                             data bits [i*WSIZE +: WSIZE]
//   addr0      master->slave  word address
//   din0       master->slave  write data
//   flush0     master->slave  pulse, restarts the init sweep
//   dout0      slave->master  read data, held until the next read completes
//   dout0_vld  slave->master  one-cycle strobe marking fresh read data
//   init_busy  slave->master  sweep in progress, accesses ignored
// ----------------------------------------------------------------------------
interface sram_1rw_masked_init_if #(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned WSIZE      = 24
);
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / WSIZE;

    logic                  csb0;
    logic                  web0_aL;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  flush0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_vld;
    logic                  init_busy;

    modport master (
        output csb0,
        output web0_aL,
        output wmask0,
        output addr0,
        output din0,
        output flush0,
        input  dout0,
        input  dout0_vld,
        input  init_busy
    );

    modport slave (
        input  csb0,
        input  web0_aL,
        input  wmask0,
        input  addr0,
        input  din0,
        input  flush0,
        output dout0,
        output dout0_vld,
        output init_busy
    );
endinterface

// File: rtl/sram_1rw_masked_init.sv
// ----------------------------------------------------------------------------
// sram_1rw_masked_init
//
// Single-port (1RW) synchronous SRAM with per-granule write mask and a
// built-in initialisation sweep. After reset, or on a flush0 pulse while
// idle, every entry is overwritten with INIT_VALUE, one entry per clock,
// before accesses are accepted again. Read data is registered and held
// until the next read completes; dout0_vld strobes for one cycle per read.
//
// Ports:
//   clk0   clock, all state changes on posedge
//   rst0   synchronous active-high reset
//   bus    sram_1rw_masked_init_if.slave (csb0, web0_aL, wmask0, addr0,
//          din0, flush0 in; dout0, dout0_vld, init_busy out)
//
// Build option:
//   SRAM_OUT_REG_EN  when defined, adds a second output register stage and
//                    read latency becomes 2 cycles. Undefined: 1 cycle.
//
// DATA_WIDTH must be a multiple of WSIZE.
// ----------------------------------------------------------------------------
module sram_1rw_masked_init #(
    parameter int unsigned           DATA_WIDTH = 48,
    parameter int unsigned           ADDR_WIDTH = 6,
    parameter int unsigned           WSIZE      = 24,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic                   clk0,
    input logic                   rst0,
    sram_1rw_masked_init_if.slave bus
);

    localparam int unsigned NUM_WMASKS = DATA_WIDTH / WSIZE;
    localparam int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] PtrLast = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] PtrOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        StInit,
        StIdle
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_vld_q, dout_vld_d;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    // Memory write port, shared by the sweep and by normal writes
    logic [NUM_WMASKS-1:0] mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Read request accepted this cycle and the array word it returns
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

`ifdef SRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic                  pipe_vld_q, pipe_vld_d;
`endif

    assign rd_data = mem_q[bus.addr0];

    // ------------------------------------------------------------------------
    // Next-state: FSM, sweep pointer and write-port steering
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = '0;
        mem_waddr = bus.addr0;
        mem_wdata = bus.din0;
        rd_en     = 1'b0;

        case (state_q)
            StInit: begin
                // All access inputs, including flush0, are ignored here
                mem_we    = '1;
                mem_waddr = ptr_q[ADDR_WIDTH-1:0];
                mem_wdata = INIT_VALUE;
                ptr_d     = ptr_q + PtrOne;
                if (ptr_q == PtrLast) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // Flush wins over a same-cycle access, which is dropped
                if (bus.flush0) begin
                    state_d = StInit;
                    ptr_d   = '0;
                end else if (!bus.csb0) begin
                    if (!bus.web0_aL) begin
                        mem_we = bus.wmask0;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StInit;
                ptr_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output path: dout holds its last read value unless a read completes
    // ------------------------------------------------------------------------
`ifdef SRAM_OUT_REG_EN
    always_comb begin
        pipe_vld_d  = rd_en;
        pipe_data_d = rd_en ? rd_data : pipe_data_q;
        // A read already in the first stage drains regardless of state
        dout_vld_d  = pipe_vld_q;
        dout_d      = pipe_vld_q ? pipe_data_q : dout_q;
    end
`else
    always_comb begin
        dout_vld_d = rd_en;
        dout_d     = rd_en ? rd_data : dout_q;
    end
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q    <= StInit;
            ptr_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

`ifdef SRAM_OUT_REG_EN
    always_ff @(posedge clk0) begin
        if (rst0) begin
            pipe_data_q <= '0;
            pipe_vld_q  <= 1'b0;
        end else begin
            pipe_data_q <= pipe_data_d;
            pipe_vld_q  <= pipe_vld_d;
        end
    end
`endif

    // Storage array: no reset, contents are defined by the sweep that
    // always follows reset. Writes are suppressed on reset edges.
    always_ff @(posedge clk0) begin
        if (!rst0) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (mem_we[i]) begin
                    mem_q[mem_waddr][i*WSIZE +: WSIZE] <= mem_wdata[i*WSIZE +: WSIZE];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.dout0     = dout_q;
    assign bus.dout0_vld = dout_vld_q;
    assign bus.init_busy = (state_q == StInit);

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// ----------------------------------------------------------------------------
// Bench for sram_1rw_masked_init. A behavioural model of the memory tracks
// expected dout0 / dout0_vld / init_busy and is compared on every falling
// edge; directed scenarios add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_sram_1rw_masked_init;

    localparam int unsigned DW         = 48;
    localparam int unsigned AW         = 6;
    localparam int unsigned WS         = 24;
    localparam int unsigned NW         = DW / WS;
    localparam int          RAM_DEPTH  = 2 ** AW;
    localparam logic [DW-1:0] INIT_VAL = '0;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk0;
    logic rst0;

    sram_1rw_masked_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WSIZE(WS)) bus ();

    sram_1rw_masked_init #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .WSIZE     (WS),
        .INIT_VALUE(INIT_VAL)
    ) dut (
        .clk0(clk0),
        .rst0(rst0),
        .bus (bus)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int errors;
    int checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: sweep modelled as a countdown of remaining edges; contents
    // become INIT_VAL when it reaches zero.
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_mem [RAM_DEPTH];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    int            m_left;
    bit            m_ready;
    logic [DW-1:0] m_pd;
    logic          m_pv;

    task automatic model_step();
        logic          rd;
        logic [DW-1:0] rdata;
        rd    = 1'b0;
        rdata = '0;
        if (rst0) begin
            m_left  = RAM_DEPTH;
            m_dout  = '0;
            m_vld   = 1'b0;
            m_pv    = 1'b0;
            m_pd    = '0;
            m_ready = 1'b1;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    for (int a = 0; a < RAM_DEPTH; a++) m_mem[a] = INIT_VAL;
                end
            end else if (bus.flush0) begin
                m_left = RAM_DEPTH;
            end else if (!bus.csb0 && !bus.web0_aL) begin
                for (int g = 0; g < int'(NW); g++) begin
                    if (bus.wmask0[g]) m_mem[bus.addr0][g*WS +: WS] = bus.din0[g*WS +: WS];
                end
            end else if (!bus.csb0) begin
                rd    = 1'b1;
                rdata = m_mem[bus.addr0];
            end
`ifdef SRAM_OUT_REG_EN
            m_vld = m_pv;
            if (m_pv) m_dout = m_pd;
            m_pv = rd;
            if (rd) m_pd = rdata;
`else
            m_vld = rd;
            if (rd) m_dout = rdata;
`endif
        end
    endtask

    initial begin
        m_ready = 1'b0;
        m_left  = 0;
        m_dout  = '0;
        m_vld   = 1'b0;
        m_pv    = 1'b0;
        m_pd    = '0;
        for (int a = 0; a < RAM_DEPTH; a++) m_mem[a] = '0;
        forever begin
            @(posedge clk0);
            model_step();
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk0);
            if (m_ready) begin
                chk("model_dout", 64'(bus.dout0), 64'(m_dout));
                chk("model_vld", 64'(bus.dout0_vld), 64'(m_vld));
                chk("model_busy", 64'(bus.init_busy), 64'(m_left > 0));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all drive at negedge)
    // ------------------------------------------------------------------------
    task automatic idle();
        bus.csb0    = 1'b1;
        bus.web0_aL = 1'b1;
        bus.wmask0  = '0;
        bus.flush0  = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m);
        bus.csb0    = 1'b0;
        bus.web0_aL = 1'b0;
        bus.addr0   = a;
        bus.din0    = d;
        bus.wmask0  = m;
        @(negedge clk0);
        idle();
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.csb0    = 1'b0;
        bus.web0_aL = 1'b1;
        bus.addr0   = a;
        @(negedge clk0);
        idle();
        repeat (LAT - 1) @(negedge clk0);
        chk(name, 64'(bus.dout0), 64'(exp));
        chk({name, "_vld"}, 64'(bus.dout0_vld), 64'd1);
    endtask

    // Counts sweep edges until init_busy drops; optionally pokes a write to
    // addr 0 and a read during the sweep, both of which must be ignored.
    task automatic count_busy(output int n, input int poke_at);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            idle();
            if (poke_at >= 0 && k == poke_at) begin
                bus.csb0    = 1'b0;
                bus.web0_aL = 1'b0;
                bus.addr0   = '0;
                bus.din0    = '1;
                bus.wmask0  = '1;
            end else if (poke_at >= 0 && k == poke_at + 1) begin
                bus.csb0    = 1'b0;
                bus.addr0   = '0;
            end
            @(negedge clk0);
            n++;
            if (bus.init_busy !== 1'b1) break;
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        int n;
        errors = 0;
        checks = 0;
        idle();
        bus.addr0 = '0;
        bus.din0  = '0;
        rst0      = 1'b1;

        // Reset for two edges, then the full sweep
        repeat (2) @(negedge clk0);
        chk("rst_busy", 64'(bus.init_busy), 64'd1);
        chk("rst_dout", 64'(bus.dout0), 64'd0);
        chk("rst_vld", 64'(bus.dout0_vld), 64'd0);
        rst0 = 1'b0;
        count_busy(n, -1);
        chk("sweep_len", 64'(n), 64'd64);
        rd_chk("rd0_after_init", 6'd0, 48'h0);
        rd_chk("rd31_after_init", 6'd31, 48'h0);
        rd_chk("rd63_after_init", 6'd63, 48'h0);

        // Masked writes
        wr(6'd5, 48'hAAAA_AA55_5555, 2'b11);
        wr(6'd5, 48'hFFFF_FF00_0000, 2'b01);
        rd_chk("masked_wr", 6'd5, 48'hAAAA_AA00_0000);
        wr(6'd5, 48'hFFFF_FFFF_FFFF, 2'b00);
        rd_chk("mask_zero_noop", 6'd5, 48'hAAAA_AA00_0000);
        wr(6'd5, 48'h1111_1122_2222, 2'b10);
        rd_chk("mask_hi_only", 6'd5, 48'h1111_1100_0000);

        // Back-to-back reads
        for (int a = 0; a < 4; a++) wr(6'(a), 48'(a + 1), 2'b11);
        for (int c = 0; c < 4 + LAT; c++) begin
            int idx;
            if (c < 4) begin
                bus.csb0    = 1'b0;
                bus.web0_aL = 1'b1;
                bus.addr0   = 6'(c);
            end else begin
                idle();
            end
            @(negedge clk0);
            idx = c + 1 - LAT;
            if (idx >= 0 && idx < 4) begin
                chk("b2b_dout", 64'(bus.dout0), 64'(idx + 1));
                chk("b2b_vld", 64'(bus.dout0_vld), 64'd1);
            end else if (idx == 4) begin
                chk("b2b_hold_dout", 64'(bus.dout0), 64'd4);
                chk("b2b_hold_vld", 64'(bus.dout0_vld), 64'd0);
            end
        end
        idle();

        // Flush beats a same-cycle write
        wr(6'd7, 48'h0000_0000_BEEF, 2'b11);
        rd_chk("pre_flush_rd7", 6'd7, 48'h0000_0000_BEEF);
        bus.flush0  = 1'b1;
        bus.csb0    = 1'b0;
        bus.web0_aL = 1'b0;
        bus.addr0   = 6'd7;
        bus.din0    = 48'h1234;
        bus.wmask0  = 2'b11;
        @(negedge clk0);
        idle();
        chk("flush_busy_rise", 64'(bus.init_busy), 64'd1);
        count_busy(n, -1);
        chk("flush_sweep_len", 64'(n), 64'd64);
        rd_chk("flush_rd7", 6'd7, 48'h0);

        wr(6'd2, 48'h3, 2'b11);
        rd_chk("rd2", 6'd2, 48'h3);

        // Reset at sweep edge 30 restarts the sweep; accesses during it ignored
        bus.flush0 = 1'b1;
        @(negedge clk0);
        idle();
        repeat (29) @(negedge clk0);
        rst0 = 1'b1;
        @(negedge clk0);
        rst0 = 1'b0;
        chk("midsweep_rst_dout", 64'(bus.dout0), 64'd0);
        chk("midsweep_rst_busy", 64'(bus.init_busy), 64'd1);
        count_busy(n, 50);
        chk("midsweep_sweep_len", 64'(n), 64'd64);
        rd_chk("poke_ignored", 6'd0, 48'h0);
        rd_chk("rd2_cleared", 6'd2, 48'h0);

        repeat (3) @(negedge clk0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_1rw_masked_init.md
# sram_1rw_masked_init

Parametrised single-port (1RW) synchronous SRAM with configurable data width, depth and write-mask granularity. It includes a built-in initialisation sweep that writes INIT_VALUE to every entry after reset or on a flush request. It is the storage primitive for the cache tag and metadata arrays, where a flush invalidates all lines without a software loop. Read data is registered and held, and a valid strobe marks it.

## Interface
- DATA_WIDTH, 48, word width in bits
- ADDR_WIDTH, 6, address width; RAM_DEPTH = 2**ADDR_WIDTH
- WSIZE, 24, write-mask granule in bits; DATA_WIDTH must be a multiple of WSIZE; NUM_WMASKS = DATA_WIDTH/WSIZE
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry by the sweep

- clk0  input  1  clock; all state changes on posedge
- rst0  input  1  reset; synchronous, active-high
- csb0  input  1  active-low chip select
- web0_aL  input  1  active-low write enable (0 = write, 1 = read)
- wmask0  input  NUM_WMASKS  per-granule write enable; bit i covers bits [i*WSIZE +: WSIZE]
- addr0  input  ADDR_WIDTH  word address
- din0  input  DATA_WIDTH  write data
- flush0  input  1  pulse; restarts the init sweep
- dout0  output  DATA_WIDTH  read data, held until the next read completes
- dout0_vld  output  1  one-cycle strobe: dout0 updated with new read data
- init_busy  output  1  sweep in progress; accesses ignored

## Operation
- FSM states: INIT, IDLE.
- INIT:
  - A pointer ptr (ADDR_WIDTH+1 bits) starts at 0.
  - Each posedge writes INIT_VALUE to mem[ptr] (all granules) and increments ptr.
  - On the edge that writes entry RAM_DEPTH-1, the FSM goes to IDLE.
  - csb0, web0_aL and flush0 are ignored in INIT.
- IDLE access with csb0=0 and web0_aL=0 (write): for each i with wmask0[i]=1, mem[addr0] granule i <= din0 granule i. Unmasked granules are unchanged. wmask0 of all zeros is a no-op.
- IDLE access with csb0=0 and web0_aL=1 (read): mem[addr0] is captured into dout0.
- IDLE with csb0=1: no operation; dout0 holds.
- IDLE with flush0=1: go to INIT with ptr=0. flush0 has priority over a same-cycle access, and that access is dropped, whether read or write.
- dout0 is never driven to X. It keeps its last read value across writes, idle cycles, INIT and flush.
- Out-of-range conditions cannot occur: addr0 covers exactly RAM_DEPTH entries.

## Timing
- Reset: any posedge with rst0=1 forces the following, regardless of other inputs:
  - state=INIT, ptr=0
  - dout0=0, dout0_vld=0, init_busy=1
- Reset mid-sweep restarts the sweep from entry 0. Reset mid-read cancels that read's dout0_vld.
- Sweep length: exactly RAM_DEPTH posedges with rst0=0 (64 at defaults).
  - init_busy falls after the last sweep edge.
  - The first access is accepted on the next edge.
- init_busy rises on the same edge that samples flush0=1.
- Read latency is 1 cycle. Inputs are sampled at edge N; dout0 is valid and dout0_vld=1 after edge N, cleared after edge N+1 unless another read is sampled.
- Back-to-back reads every cycle are supported: dout0_vld stays high continuously.
- Write then read of the same address on consecutive edges returns the new data.

## Configuration
- SRAM_OUT_REG_EN defined:
  - Adds a second output register stage.
  - Read latency becomes 2 cycles: data sampled at edge N appears after edge N+1, with dout0_vld delayed identically.
  - Reset and flush clear the pipeline-stage valid bit; a read in flight when flush0 is accepted still completes.
- SRAM_OUT_REG_EN undefined: 1-cycle latency as above. There is no extra register.

## Test plan
- Reset then sweep: rst0=1 for 2 cycles, then 0 with defaults. init_busy=1 for exactly 64 edges, then 0. Reads of addresses 0, 31 and 63 return 0 with dout0_vld=1 one cycle later.
- Masked write: write 0xAAAA_AA55_5555 to addr 5 with wmask0=2'b11, then write 0xFFFF_FF00_0000 with wmask0=2'b01. A read of addr 5 returns 0xAAAA_AA00_0000.
- Back-to-back: write addrs 0..3 with data = addr+1, then read 0..3 on four consecutive edges. dout0_vld is high for 4 consecutive cycles with values 1, 2, 3, 4. dout0 holds 4 afterward with vld=0.
- Flush priority: in IDLE, drive flush0=1 with a write of 0x1234 to addr 7 in the same cycle. init_busy rises and stays high 64 cycles, and a later read of addr 7 returns 0.
- Reset mid-sweep: assert rst0 for 1 cycle at sweep edge 30. init_busy stays high for 64 further edges. Accesses issued during INIT are ignored, and mem is unchanged by them.
- SRAM_OUT_REG_EN: rebuild with the macro. Reading addr 2 (holding 0x3) gives dout0=0x3 and dout0_vld=1 two cycles after sampling. Other scenarios pass with the latency shifted by +1.
